// File: rtl/mips_cpu_hilo_mult_div.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Every operation takes WIDTH+1 edges from acceptance to a one-cycle done pulse.
module mips_cpu_hilo_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       op_r;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CW-1:0]    count;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Signed ops (op[0]=0) work on magnitudes; signs are restored in FIX.
    always_comb begin
        sign_a = ~op[0] & operand_a[WIDTH-1];
        sign_b = ~op[0] & operand_b[WIDTH-1];
        mag_a  = sign_a ? (~operand_a + 1'b1) : operand_a;
        mag_b  = sign_b ? (~operand_b + 1'b1) : operand_b;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        add_sum = {1'b0, p_hi} + {1'b0, m_reg};
        trial   = {p_hi, p_lo[WIDTH-1]} - {1'b0, m_reg};
        step_hi = p_hi;
        step_lo = p_lo;
        if (op_r[1]) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {p_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                step_lo = {p_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (p_lo[0]) begin
                step_hi = add_sum[WIDTH:1];
                step_lo = {add_sum[0], p_lo[WIDTH-1:1]};
            end else begin
                step_hi = {1'b0, p_hi[WIDTH-1:1]};
                step_lo = {p_hi[0], p_lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {p_hi, p_lo};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q ? (~p_lo + 1'b1) : p_lo;
        rem_fix  = neg_r ? (~p_hi + 1'b1) : p_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_r   <= 2'b00;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            a_orig <= '0;
            m_reg  <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        div0   <= op[1] & (operand_b == '0);
                        a_orig <= operand_a;
                        // Divide: p_lo=dividend, m_reg=divisor. Multiply: p_lo=multiplier.
                        m_reg  <= op[1] ? mag_b : mag_a;
                        p_lo   <= op[1] ? mag_a : mag_b;
                        p_hi   <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (write_hi) hi <= write_data;
                        if (write_lo) lo <= write_data;
                    end
                end
                RUN: begin
                    p_hi  <= step_hi;
                    p_lo  <= step_lo;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!op_r[1]) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div0) begin
                        hi <= a_orig;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_hilo_mult_div.sv
// Randomized bench for the HI/LO multiply/divide unit against a 64-bit arithmetic model.
module tb_mips_cpu_hilo_mult_div;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        write_hi = 1'b0;
    logic        write_lo = 1'b0;
    logic [31:0] write_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mips_cpu_hilo_mult_div #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi,lo} from the architectural definition of each op.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        int ia, ib, q, r;
        case (o)
            2'b00: begin
                sa = $signed(a);
                sb = $signed(b);
                return 64'(sa * sb);
            end
            2'b01: begin
                ua = 64'(a);
                ub = 64'(b);
                return ua * ub;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                q = ia / ib;
                r = ia % ib;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at #1 after an edge; the next edge is E0.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit with_strobes);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        write_hi = with_strobes;
        write_lo = with_strobes;
        write_data = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        write_hi = 1'b0;
        write_lo = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        check("busy_after_e0", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int n, output int busy_cnt, output bit stable);
        n = 0;
        stable = 1'b1;
        busy_cnt = busy ? 1 : 0;
        while (n < 45) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
            if (done) break;
            if (hi !== model_hi || lo !== model_lo) stable = 1'b0;
        end
        if (!done) begin
            check("done_timeout", 64'(n), 64'd33);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_strobes, input bit check_pulse);
        int n, bc;
        bit st;
        logic [63:0] exp;
        exp = ref_result(o, a, b);
        start_op(o, a, b, with_strobes);
        wait_done(n, bc, st);
        check("latency", 64'(n), 64'd33);
        check("busy_cycles", 64'(bc), 64'd33);
        check("stable_during_run", {63'b0, st}, 64'd1);
        check("result", {hi, lo}, exp);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        if (check_pulse) begin
            @(posedge clk);
            #1;
            check("done_one_cycle", {63'b0, done}, 64'd0);
            check("busy_idle", {63'b0, busy}, 64'd0);
        end
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        write_hi = wh;
        write_lo = wl;
        write_data = d;
        @(posedge clk);
        #1;
        write_hi = 1'b0;
        write_lo = 1'b0;
        if (wh) model_hi = d;
        if (wl) model_lo = d;
        check("mt_hi", 64'(hi), 64'(model_hi));
        check("mt_lo", 64'(lo), 64'(model_lo));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, bc;
        bit st;
        bit saw_done;

        #12;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: MULTU max*max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("t1_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        // 2: MULT -3*7
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1);
        check("t2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        // 3: DIV -7/2 then overflow case
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        check("t3a_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("t3b_const", {hi, lo}, 64'h0000_0000_8000_0000);
        // 4: divide by zero, then back-to-back start in the done cycle
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        check("t4a_const", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
        check("t4b_const", {hi, lo}, {32'd2, 32'd14});
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1);
        check("t4c_sdiv0", {hi, lo}, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

        // 5: mid-run start and MTLO are ignored
        start_op(2'b01, 32'd5, 32'd6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        op = 2'b11;
        operand_a = 32'd9;
        operand_b = 32'd3;
        write_lo = 1'b1;
        write_data = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        write_lo = 1'b0;
        wait_done(n, bc, st);
        check("t5_latency", 64'(n + 4), 64'd33);
        check("t5_result", {hi, lo}, {32'd0, 32'd30});
        model_hi = 32'd0;
        model_lo = 32'd30;
        @(posedge clk);
        #1;
        check("t5_no_second_op", {62'b0, busy, done}, 64'd0);
        mt_write(1'b1, 1'b0, 32'hABCD);
        check("t5_hi_const", 64'(hi), 64'hABCD);
        mt_write(1'b1, 1'b1, 32'h5A5A_0F0F);

        // 6: asynchronous reset in the middle of a divide
        start_op(2'b11, 32'd50, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_busy", {63'b0, busy}, 64'd0);
        check("t6_done", {63'b0, done}, 64'd0);
        check("t6_hilo", {hi, lo}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("t6_no_done", {63'b0, saw_done}, 64'd0);
        check("t6_hilo_hold", {hi, lo}, 64'd0);
        run_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1);
        check("t6_const", 64'(lo), 64'd6);

        // Random ops, interleaved with MT writes and start-with-strobe collisions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
